// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

  localparam int ALU_W  = 8;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_NOTB  = 3'b100,
    OP_PASSB = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic logic op_implemented(input logic [2:0] op);
    return op <= OP_PASSB;
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way winner select. Round-robin by default; define ALU_ARB_FIXED_PRIO_EN
// to make requester 0 always win.
module alu_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any_o,
  output logic win1_o
);

  assign any_o = req0 | req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win1_o = req1 & ~req0;
`else
  // ptr_q set means requester 1 is favoured on a tie.
  logic ptr_q;
  logic ptr_d;

  assign win1_o = req1 & (~req0 | ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = ~win1_o;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: IDLE -> ISSUE -> WAIT -> DONE,
// with unimplemented opcodes short-circuiting IDLE -> DONE and flagging err_o.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [ALU_W-1:0] a0,
  input  logic [ALU_W-1:0] b0,
  input  logic [ALU_W-1:0] a1,
  input  logic [ALU_W-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [ALU_W-1:0] res_o,
  output logic [3:0]       flags_o,
  output logic             err_o,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [2:0]       alu_cntr,
  input  logic [ALU_W-1:0] alu_r,
  input  logic [3:0]       alu_flags,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a requester raises req with op/a/b stable and holds them until
  // it sees its gnt pulse; operands are latched in IDLE, so later changes are
  // ignored. done marks res_o/flags_o/err_o valid; they hold until next capture.

  arb_state_e       state_q, state_d;
  logic             sel_q, sel_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [ALU_W-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [ALU_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_cntr_q, alu_cntr_d;

  logic             any_req;
  logic             win1;
  logic             take;
  logic [2:0]       op_sel;
  logic [ALU_W-1:0] a_sel, b_sel;

  assign take   = (state_q == ST_IDLE) && any_req;
  assign op_sel = win1 ? op1 : op0;
  assign a_sel  = win1 ? a1  : a0;
  assign b_sel  = win1 ? b1  : b0;

  alu_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .take   (take),
    .any_o  (any_req),
    .win1_o (win1)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    res_d      = res_q;
    flags_d    = flags_q;
    err_d      = err_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cntr_d = alu_cntr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d  = win1;
          gnt0_d = ~win1;
          gnt1_d = win1;
          if (op_implemented(op_sel)) begin
            alu_a_d    = a_sel;
            alu_b_d    = b_sel;
            alu_cntr_d = op_sel;
            state_d    = ST_ISSUE;
          end else begin
            // The ALU is never touched; grant and completion coincide.
            done0_d = ~win1;
            done1_d = win1;
            res_d   = '0;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        res_d   = alu_r;
        flags_d = alu_flags;
        err_d   = 1'b0;
        done0_d = ~sel_q;
        done1_d = sel_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cntr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cntr_q <= alu_cntr_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign res_o       = res_q;
  assign flags_o     = flags_q;
  assign err_o       = err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cntr    = alu_cntr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU (carry on subtract = borrow).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] res_o;
  logic [3:0] flags_o;
  logic       err_o;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_cntr;
  logic [7:0] alu_r;
  logic [3:0] alu_flags;
  logic [1:0] dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .res_o(res_o), .flags_o(flags_o), .err_o(err_o),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntr(alu_cntr), .alu_r(alu_r),
    .alu_flags(alu_flags), .dbg_state_o(dbg_state_o)
  );

  // Shared ALU model, flags {N,Z,C,V}.
  always_comb begin
    logic [8:0] wide;
    logic       c, v;
    wide = 9'd0;
    c = 1'b0;
    v = 1'b0;
    case (alu_cntr)
      3'b000: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        c = wide[8];
        v = (alu_a[7] == alu_b[7]) && (wide[7] != alu_a[7]);
      end
      3'b001: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        c = alu_a < alu_b;
        v = (alu_a[7] != alu_b[7]) && (wide[7] != alu_a[7]);
      end
      3'b010:  wide = {1'b0, alu_a & alu_b};
      3'b011:  wide = {1'b0, alu_a | alu_b};
      3'b100:  wide = {1'b0, ~alu_b};
      3'b101:  wide = {1'b0, alu_b};
      default: wide = 9'd0;
    endcase
    alu_r     = wide[7:0];
    alu_flags = {wide[7], wide[7:0] == 8'd0, c, v};
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic e1;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 3'd0; op1 = 3'd0;
    a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
    step();
    step();
    chk("rst_gnt0", gnt0, 0);       chk("rst_gnt1", gnt1, 0);
    chk("rst_done0", done0, 0);     chk("rst_done1", done1, 0);
    chk("rst_res", res_o, 0);       chk("rst_flags", flags_o, 0);
    chk("rst_err", err_o, 0);       chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);     chk("rst_cntr", alu_cntr, 0);
    chk("rst_state", dbg_state_o, 0);
    rst = 1'b0;

    // 5 + 3 from requester 0; latency gnt t+1, done t+3
    req0 = 1'b1; op0 = 3'b000; a0 = 8'd5; b0 = 8'd3;
    step();
    chk("add_gnt0", gnt0, 1);       chk("add_gnt1", gnt1, 0);
    chk("add_done0_early", done0, 0);
    chk("add_alu_a", alu_a, 5);     chk("add_alu_b", alu_b, 3);
    chk("add_cntr", alu_cntr, 0);   chk("add_state_issue", dbg_state_o, 1);
    req0 = 1'b0; a0 = 8'd99; b0 = 8'd99; op0 = 3'b011;
    step();
    chk("add_gnt0_pulse", gnt0, 0); chk("add_state_wait", dbg_state_o, 2);
    chk("add_alu_a_hold", alu_a, 5); chk("add_done0_wait", done0, 0);
    step();
    chk("add_done0", done0, 1);     chk("add_done1", done1, 0);
    chk("add_res", res_o, 8'd8);    chk("add_flags", flags_o, 4'b0000);
    chk("add_err", err_o, 0);
    step();
    chk("add_done0_pulse", done0, 0); chk("add_res_hold", res_o, 8'd8);
    chk("add_state_idle", dbg_state_o, 0);

    // Tie after reset: requester 0 first, then 1
    do_reset();
    req0 = 1'b1; req1 = 1'b1; op0 = 3'b001; op1 = 3'b001;
    a0 = 8'd4; b0 = 8'd4; a1 = 8'd1; b1 = 8'd2;
    step();
    chk("tie_gnt0", gnt0, 1);       chk("tie_gnt1_low", gnt1, 0);
    req0 = 1'b0;
    step();
    step();
    chk("sub0_done0", done0, 1);    chk("sub0_done1", done1, 0);
    chk("sub0_res", res_o, 8'h00);  chk("sub0_flags", flags_o, 4'b0100);
    step();
    chk("sub1_gnt1_idle", gnt1, 0);
    step();
    chk("sub1_gnt1", gnt1, 1);      chk("sub1_gnt0", gnt0, 0);
    chk("sub1_alu_a", alu_a, 1);    chk("sub1_alu_b", alu_b, 2);
    req1 = 1'b0;
    step();
    step();
    chk("sub1_done1", done1, 1);    chk("sub1_done0", done0, 0);
    chk("sub1_res", res_o, 8'hFF);  chk("sub1_flags", flags_o, 4'b1010);
    step();

    // Unimplemented opcode: gnt and done together, ALU untouched
    req1 = 1'b1; op1 = 3'b110; a1 = 8'd7; b1 = 8'd7;
    step();
    chk("unimp_gnt1", gnt1, 1);     chk("unimp_done1", done1, 1);
    chk("unimp_gnt0", gnt0, 0);     chk("unimp_done0", done0, 0);
    chk("unimp_err", err_o, 1);     chk("unimp_res", res_o, 0);
    chk("unimp_flags", flags_o, 0); chk("unimp_cntr", alu_cntr, 3'b001);
    chk("unimp_alu_a", alu_a, 1);
    req1 = 1'b0;
    step();
    chk("unimp_gnt1_pulse", gnt1, 0); chk("unimp_done1_pulse", done1, 0);
    chk("unimp_err_hold", err_o, 1);  chk("unimp_state_idle", dbg_state_o, 0);

    // Signed overflow 127 + 1
    req0 = 1'b1; op0 = 3'b000; a0 = 8'd127; b0 = 8'd1;
    step();
    chk("ovf_gnt0", gnt0, 1);
    req0 = 1'b0;
    step();
    step();
    chk("ovf_done0", done0, 1);     chk("ovf_res", res_o, 8'h80);
    chk("ovf_flags", flags_o, 4'b1001); chk("ovf_err_clr", err_o, 0);
    step();

    // Both held for four operations
    do_reset();
    req0 = 1'b1; req1 = 1'b1; op0 = 3'b000; op1 = 3'b000;
    a0 = 8'd10; b0 = 8'd1; a1 = 8'd20; b1 = 8'd2;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      e1 = 1'b0;
`else
      e1 = (k % 2) == 1;
`endif
      step();
      chk($sformatf("rr%0d_gnt1", k), gnt1, e1);
      chk($sformatf("rr%0d_gnt0", k), gnt0, !e1);
      step();
      step();
      chk($sformatf("rr%0d_done1", k), done1, e1);
      chk($sformatf("rr%0d_done0", k), done0, !e1);
      chk($sformatf("rr%0d_res", k), res_o, e1 ? 8'd22 : 8'd11);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset while waiting on the ALU
    step();
    req0 = 1'b1; op0 = 3'b000; a0 = 8'd2; b0 = 8'd2;
    step();
    chk("rstw_gnt0", gnt0, 1);
    req0 = 1'b0;
    step();
    chk("rstw_state_wait", dbg_state_o, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_done0", done0, 0);    chk("rstw_res", res_o, 0);
    chk("rstw_flags", flags_o, 0);  chk("rstw_alu_a", alu_a, 0);
    chk("rstw_alu_b", alu_b, 0);    chk("rstw_cntr", alu_cntr, 0);
    chk("rstw_state", dbg_state_o, 0);
    step();
    chk("rstw_done0_after", done0, 0);
    req1 = 1'b1; op1 = 3'b011; a1 = 8'hF0; b1 = 8'h0F;
    step();
    chk("post_gnt1", gnt1, 1);
    req1 = 1'b0;
    step();
    step();
    chk("post_done1", done1, 1);    chk("post_res", res_o, 8'hFF);
    chk("post_flags", flags_o, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the block's only clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports req0/req1, input, 1 each, request from requester 0/1.
REQ-004 SHALL have ports op0/op1, input, 3 each, opcode: 000 add, 001 sub, 010 and, 011 or, 100 not-B, 101 pass-B, 110/111 unimplemented.
REQ-005 SHALL have ports a0/b0/a1/b1, input, 8 each, signed operands.
REQ-006 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle grant pulse.
REQ-007 SHALL have ports done0/done1, output, 1 each, one-cycle completion pulse.
REQ-008 SHALL have ports res_o (output, 8, result), flags_o (output, 4, {N,Z,C,V}) and err_o (output, 1, unimplemented opcode), all valid with done.
REQ-009 SHALL have ports alu_a, alu_b (output, 8), alu_cntr (output, 3) driving the shared ALU, and alu_r (input, 8), alu_flags (input, 4) returned by it.

Function
REQ-010 SHALL implement FSM IDLE, ISSUE, WAIT, DONE.
REQ-011 IDLE: if no req, stay; otherwise select the winner, latch its op/a/b, then go to ISSUE (implemented op) or DONE (op 110/111).
REQ-012 ISSUE: SHALL drive latched operands on alu_a/alu_b/alu_cntr (registered), pulse gnt of the winner, then go to WAIT.
REQ-013 WAIT: SHALL hold alu_* stable, capture alu_r into res_o and alu_flags into flags_o at cycle end, clear err_o, then go to DONE.
REQ-014 DONE: SHALL pulse the winner's done for exactly one cycle, then go to IDLE.
REQ-015 Latency, implemented op: req sampled in IDLE at cycle t -> gnt at t+1 -> done at t+3. Throughput: one operation per 4 cycles.
REQ-016 Unimplemented op: SHALL not drive the ALU (alu_cntr keeps its previous value), SHALL pulse gnt and done together in DONE at t+1, with res_o=0, flags_o=0, err_o=1.
REQ-017 Requester SHALL hold req and operands until its gnt; operands changing after latching SHALL NOT affect the result.
REQ-018 Simultaneous req0 and req1 SHALL be resolved round-robin: the requester that did not win last time wins; after reset, requester 0 is favoured.
REQ-019 A req still high in the cycle after done SHALL be treated as a new request.
REQ-020 res_o/flags_o/err_o SHALL hold their values until the next capture.
REQ-021 gnt0/gnt1 SHALL be mutually exclusive; so SHALL done0/done1.

Reset
REQ-022 rst SHALL force IDLE and set the round-robin pointer to favour requester 0.
REQ-023 rst SHALL zero gnt*, done*, res_o, flags_o, err_o, alu_a, alu_b and alu_cntr.
REQ-024 rst mid-operation SHALL abandon the transaction with no done pulse.

Configuration
REQ-025 With ALU_ARB_FIXED_PRIO_EN defined, req0 SHALL always win over req1; without it, REQ-018 round-robin applies.

Structure
REQ-026 Package alu_pkg SHALL hold the opcode enum, the flag bit indices (N=3, Z=2, C=1, V=0) and the operand width constant (8).
REQ-027 Winner selection SHALL be a sub-module alu_rr_arb (2-way round-robin, pointer updated on grant).

Verification
REQ-028 req0=1, op0=000, a0=5, b0=3 -> gnt0 at t+1, done0 at t+3, res_o=8, flags_o=0000, err_o=0.
REQ-029 req0 and req1 both high, op=001, a0=4, b0=4 and a1=1, b1=2 -> done0 first with res_o=0, Z=1; then done1 with res_o=0xFF, N=1.
REQ-030 req1=1, op1=110 -> gnt1 and done1 at t+1, err_o=1, res_o=0; alu_cntr unchanged.
REQ-031 req0 and req1 held high for 4 operations -> grants alternate 0,1,0,1 (0,0,0,0 with ALU_ARB_FIXED_PRIO_EN).
REQ-032 rst asserted during WAIT -> no done pulse; all outputs 0 next cycle; the next request completes normally.
REQ-033 op0=000, a0=127, b0=1 -> res_o=0x80, N=1, V=1.
